// File: rtl/z80_io_capture.sv
// Z80 IO mailbox front end: strobe synchronisers, glitch-qualified cycle FSM, port decode and write FIFO.
// Optional macro Z80_IO_WAIT_EN adds z80_wait_n and stalls full-FIFO writes instead of dropping them.
module z80_io_capture #(
  parameter logic [15:0] IO_BASE     = 16'd12345,
  parameter int unsigned IO_STRIDE   = 2,
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned QUAL_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   z80_a,
  input  logic [7:0]                    z80_d_in,
  input  logic                          z80_rd,
  input  logic                          z80_wr,
  input  logic                          z80_iorq,
  input  logic                          z80_mreq,
  input  logic                          z80_m1,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [2:0]                    wr_index,
  output logic [7:0]                    wr_data,
  output logic                          rd_stb,
  output logic [2:0]                    rd_index,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
`ifdef Z80_IO_WAIT_EN
  ,
  output logic                          z80_wait_n
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(QUAL_CYCLES + 1);
  localparam logic [15:0] STRIDE = 16'(IO_STRIDE);
  localparam logic [15:0] SPAN = 16'(NUM_PORTS * IO_STRIDE);
  localparam logic [CW-1:0] QUAL_LAST = CW'(QUAL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_CAPTURE, S_HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [4:0]      sync_q1;
  logic [4:0]      sync_q2;
  logic            rd_s, wr_s, iorq_s, mreq_s, m1_s, io_cyc;
  logic [15:0]     off;
  logic            hit;
  logic [2:0]      idx;
  logic            cap_wr, cap_rd;
  logic            full, pop, stall, push, accept, drop;
  logic [10:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;

  // Preset high so a reset mid-cycle looks like idle strobes until re-synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= {z80_rd, z80_wr, z80_iorq, z80_mreq, z80_m1};
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    {rd_s, wr_s, iorq_s, mreq_s, m1_s} = sync_q2;
    io_cyc  = !iorq_s && mreq_s && m1_s && (rd_s ^ wr_s);
    cnt_nxt = cnt + CW'(1);
  end

  // Address and data are sampled raw: by CAPTURE the strobe has been low long enough for them to settle.
  always_comb begin
    off    = z80_a - IO_BASE;
    hit    = (off < SPAN) && ((off % STRIDE) == 16'd0);
    idx    = 3'(off / STRIDE);
    cap_wr = (state == S_CAPTURE) && hit && !wr_s && rd_s;
    cap_rd = (state == S_CAPTURE) && hit && !rd_s && wr_s;
  end

  always_comb begin
    full   = (fifo_level == LW'(FIFO_DEPTH));
    wr_valid = (fifo_level != '0);
    pop    = wr_valid && wr_ready;
`ifdef Z80_IO_WAIT_EN
    stall  = cap_wr && full && !pop;
`else
    stall  = 1'b0;
`endif
    push   = cap_wr && !stall;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    {wr_index, wr_data} = mem[rptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rd_stb   <= 1'b0;
      rd_index <= '0;
`ifdef Z80_IO_WAIT_EN
      z80_wait_n <= 1'b1;
`endif
    end else begin
      rd_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io_cyc) begin
            cnt   <= CW'(1);
            state <= (QUAL_CYCLES <= 1) ? S_CAPTURE : S_QUAL;
          end
        end
        S_QUAL: begin
          if (!io_cyc) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == QUAL_LAST) state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
`ifdef Z80_IO_WAIT_EN
          z80_wait_n <= !stall;
`endif
          if (!stall) begin
            state <= S_HOLD;
            if (cap_rd) begin
              rd_stb   <= 1'b1;
              rd_index <= idx;
            end
          end
        end
        S_HOLD: begin
          // One event per bus cycle: wait for both strobes to release.
          if (rd_s && wr_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (accept) begin
        mem[wptr] <= {idx, z80_d_in};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_io_capture.sv
// Scoreboard bench for z80_io_capture: directed bus cycles plus randomized traffic against a queue model.
module tb_z80_io_capture;
  localparam logic [15:0] BASE = 16'd12345;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] z80_a = '0;
  logic [7:0]  z80_d_in = '0;
  logic        z80_rd = 1'b1, z80_wr = 1'b1, z80_iorq = 1'b1, z80_mreq = 1'b1, z80_m1 = 1'b1;
  logic        wr_ready = 1'b0, ovf_clr = 1'b0;
  logic        wr_valid, rd_stb, overflow;
  logic [2:0]  wr_index, rd_index;
  logic [7:0]  wr_data;
  logic [2:0]  fifo_level;
`ifdef Z80_IO_WAIT_EN
  logic        z80_wait_n;
`endif

  int checks = 0, failures = 0;
  logic [10:0] exp_wr[$];
  logic [2:0]  exp_rd[$];
  logic        exp_ovf = 1'b0;
  bit          rnd_ready = 1'b0;

  z80_io_capture dut (
    .clk(clk), .rst_n(rst_n), .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_iorq(z80_iorq), .z80_mreq(z80_mreq), .z80_m1(z80_m1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_index(rd_index), .fifo_level(fifo_level), .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef Z80_IO_WAIT_EN
    , .z80_wait_n(z80_wait_n)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Mailbox decode from the port map: ports at BASE, BASE+2, ... BASE+14.
  function automatic bit decode(input logic [15:0] a, output logic [2:0] idx);
    int off;
    off = (int'(a) - int'(BASE) + 65536) % 65536;
    idx = 3'(off / 2);
    return (off < 16) && (off % 2 == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  // len = edges with the raw strobe low; pulse = edge offset at which wr_ready is held for one cycle.
  task automatic bus(input bit rd, input logic [15:0] a, input logic [7:0] d, input int len, input int pulse);
    logic [2:0] idx;
    bit hit;
    bit acc;
    hit = decode(a, idx);
`ifdef Z80_IO_WAIT_EN
    acc = 1'b1;
`else
    acc = (exp_wr.size() < DEPTH) || (pulse == 4);
`endif
    if (hit && len >= 4) begin
      if (rd) exp_rd.push_back(idx);
      else if (acc) exp_wr.push_back({idx, d});
      else exp_ovf = 1'b1;
    end
    z80_a = a; z80_d_in = d; z80_iorq = 1'b0;
    if (rd) z80_rd = 1'b0; else z80_wr = 1'b0;
    for (int k = 0; k < len; k++) begin
      tick();
      if (pulse >= 0) wr_ready = (k == pulse);
    end
    z80_rd = 1'b1; z80_wr = 1'b1; z80_iorq = 1'b1;
    repeat (5) tick();
  endtask

  task automatic drain();
    int n;
    bit r;
    n = 0;
    r = rnd_ready;
    rnd_ready = 1'b0;
    wr_ready = 1'b1;
    while (exp_wr.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    wr_ready = 1'b0;
    tick();
    chk("drain_empty", 32'(exp_wr.size()), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);
    rnd_ready = r;
  endtask

  // Monitor: every handshake and every read strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected actual=%0h required=none", {wr_index, wr_data});
        end else begin
          chk("wr_entry", 32'({wr_index, wr_data}), 32'(exp_wr.pop_front()));
        end
      end
      if (rd_stb) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=%0d required=none", rd_index);
        end else begin
          chk("rd_index", 32'(rd_index), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_index", 32'(wr_index), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_rd_stb", 32'(rd_stb), 0);
    chk("rst_rd_index", 32'(rd_index), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", 32'(overflow), 0);
`ifdef Z80_IO_WAIT_EN
    chk("rst_wait_n", 32'(z80_wait_n), 1);
`endif
    rst_n = 1'b1;
    repeat (3) tick();

    // Long write strobe produces exactly one entry.
    bus(1'b0, BASE, 8'h5A, 10, -1);
    chk("t1_valid", 32'(wr_valid), 1);
    chk("t1_index", 32'(wr_index), 0);
    chk("t1_data", 32'(wr_data), 32'h5A);
    chk("t1_level", 32'(fifo_level), 1);
    drain();

    // Read of last port; odd offset and out-of-range writes are ignored.
    bus(1'b1, BASE + 16'd14, 8'h00, 8, -1);
    bus(1'b0, BASE + 16'd1, 8'hAA, 8, -1);
    bus(1'b0, BASE + 16'd16, 8'hBB, 8, -1);
    chk("t2_level", 32'(fifo_level), 0);
    chk("t2_rd_seen", 32'(exp_rd.size()), 0);

    // Glitch rejection.
    bus(1'b0, BASE + 16'd4, 8'hC3, 2, -1);
    chk("t3_glitch_level", 32'(fifo_level), 0);
    bus(1'b0, BASE + 16'd4, 8'hC3, 4, -1);
    chk("t3_level", 32'(fifo_level), 1);
    drain();

`ifndef Z80_IO_WAIT_EN
    // Overflow on the fifth write.
    for (int i = 1; i <= 5; i++) bus(1'b0, BASE + 16'd6, 8'(i), 6, -1);
    chk("t4_level", 32'(fifo_level), 4);
    chk("t4_overflow", 32'(overflow), 32'(exp_ovf));
    drain();
    chk("t4_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; exp_ovf = 1'b0; tick();
    chk("t4_clear", 32'(overflow), 32'(exp_ovf));

    // Full FIFO with a pop on the capture edge accepts the write.
    for (int i = 0; i < 4; i++) bus(1'b0, BASE + 16'd2, 8'(8'h10 + i), 6, -1);
    bus(1'b0, BASE + 16'd2, 8'h77, 8, 4);
    chk("t5_level", 32'(fifo_level), 4);
    chk("t5_overflow", 32'(overflow), 0);
    drain();
`else
    // Full FIFO stalls the write with wait asserted until a pop frees space.
    for (int i = 1; i <= 4; i++) bus(1'b0, BASE + 16'd6, 8'(i), 6, -1);
    exp_wr.push_back({3'd5, 8'h33});
    z80_a = BASE + 16'd10; z80_d_in = 8'h33; z80_iorq = 1'b0; z80_wr = 1'b0;
    repeat (10) tick();
    chk("w_wait_low", 32'(z80_wait_n), 0);
    chk("w_level_full", 32'(fifo_level), 4);
    wr_ready = 1'b1; tick(); wr_ready = 1'b0; tick();
    chk("w_wait_high", 32'(z80_wait_n), 1);
    chk("w_level", 32'(fifo_level), 4);
    z80_wr = 1'b1; z80_iorq = 1'b1;
    repeat (5) tick();
    chk("w_overflow", 32'(overflow), 0);
    drain();

    // Reset during a stall.
    for (int i = 0; i < 4; i++) bus(1'b0, BASE, 8'(8'h40 + i), 6, -1);
    z80_a = BASE; z80_d_in = 8'h99; z80_iorq = 1'b0; z80_wr = 1'b0;
    repeat (10) tick();
    chk("r_wait_low", 32'(z80_wait_n), 0);
    rst_n = 1'b0;
    #1;
    exp_wr.delete();
    chk("r_wait_high", 32'(z80_wait_n), 1);
    chk("r_level", 32'(fifo_level), 0);
    z80_wr = 1'b1; z80_iorq = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("r_level_after", 32'(fifo_level), 0);
`endif

    // Randomized traffic; the model queue never reaches full here.
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      if (exp_wr.size() >= 3) drain();
      if ($urandom_range(0, 3) != 0) a = BASE + 16'($urandom_range(0, 17));
      else a = 16'($urandom);
      bus(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(5, 12), -1);
    end
    drain();
    chk("end_rd_queue", 32'(exp_rd.size()), 0);
    chk("end_overflow", 32'(overflow), 32'(exp_ovf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z80_io_capture.md
Name: z80_io_capture

Overview:
- Upstream front end of the Z80 IO mailbox path; sits between the raw Z80 bus pins and the SPI transfer state machine.
- Synchronises the asynchronous Z80 strobes into the clk domain and qualifies IO cycles against a glitch filter.
- Decodes the 8 mailbox ports and latches address and data.
- Delivers Z80 writes through a small FIFO with valid/ready handshake; emits single-cycle read-notify strobes.

Parameters:
- IO_BASE, 16'd12345, first mailbox port address.
- IO_STRIDE, 2, address step between consecutive ports.
- NUM_PORTS, 8, number of ports (index width 3).
- FIFO_DEPTH, 4, write FIFO entries; power of two, 2..16.
- QUAL_CYCLES, 3, clk cycles a synchronised strobe must stay low before the cycle is accepted.

Ports:
- clk  input  1  system clock (internal HF oscillator domain).
- rst_n  input  1  asynchronous active-low reset.
- z80_a  input  16  Z80 address bus (raw).
- z80_d_in  input  8  Z80 data bus input path (raw).
- z80_rd  input  1  Z80 /RD, active low.
- z80_wr  input  1  Z80 /WR, active low.
- z80_iorq  input  1  Z80 /IORQ, active low.
- z80_mreq  input  1  Z80 /MREQ, active low.
- z80_m1  input  1  Z80 /M1, active low.
- wr_valid  output  1  FIFO non-empty.
- wr_ready  input  1  downstream accepts the head entry.
- wr_index  output  3  port index of the head entry.
- wr_data  output  8  data byte of the head entry.
- rd_stb  output  1  one-cycle pulse: Z80 has read port rd_index.
- rd_index  output  3  index of the last read port.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a write was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (rst_n low, async): every output returns to 0 (wr_valid, wr_index, wr_data, rd_stb, rd_index, fifo_level, overflow); FIFO is empty; FSM is IDLE; synchronisers are preset to 1 (strobes inactive).
- Synchronisers: 2-FF on z80_rd, z80_wr, z80_iorq, z80_mreq, z80_m1.
- io_cyc = iorq_s low AND mreq_s high AND m1_s high AND exactly one of rd_s/wr_s low.
- Both rd_s and wr_s low together: not an io_cyc; no event.
- FSM states:
  - IDLE: io_cyc -> QUAL, counter = 1.
  - QUAL: io_cyc held -> counter increments. io_cyc drops before counter reaches QUAL_CYCLES -> back to IDLE, no event (glitch rejected). Counter == QUAL_CYCLES -> CAPTURE.
  - CAPTURE (1 cycle): sample z80_a and z80_d_in raw (stable by now). off = z80_a - IO_BASE, 16-bit unsigned. The port is a hit when off < NUM_PORTS*IO_STRIDE and off % IO_STRIDE == 0; index = off / IO_STRIDE. Hit write -> push {index, data}. Hit read -> rd_stb = 1 next cycle, rd_index = index. Miss -> no event. Go to HOLD.
  - HOLD: wait until rd_s and wr_s are both high -> IDLE. This guarantees exactly one event per bus cycle, however long the strobe is held.
- FIFO rules:
  - wr_valid = level != 0; wr_index/wr_data show the head.
  - Pop when wr_valid AND wr_ready.
  - Push while full without a same-cycle pop: entry dropped, overflow set to 1.
  - Push while full with a same-cycle pop: push accepted, level unchanged.
  - Push and pop together on a non-full FIFO: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency: CAPTURE edge to wr_valid high = 1 clk.
- overflow: ovf_clr clears it. A drop in the same cycle as ovf_clr wins (overflow stays 1).
- A reset in the middle of a bus cycle forces IDLE with synchronisers high. The ongoing cycle is then seen as a new io_cyc only after the strobes are re-qualified.

Optional Feature:
- Macro: Z80_IO_WAIT_EN.
- Defined:
  - Adds output z80_wait_n (1 bit, reset value 1).
  - In CAPTURE, a hit write with FIFO full and no same-cycle pop drives z80_wait_n low and stalls in CAPTURE.
  - The push happens on the first cycle with space; z80_wait_n returns to 1 the following cycle.
  - overflow never sets from writes.
- Undefined: no z80_wait_n port; full-FIFO writes are dropped and set overflow.

Test Plan:
- OUT to 12345 with data 0x5A, /WR low 10 clk, wr_ready = 0 -> wr_valid = 1, wr_index = 0, wr_data = 0x5A, fifo_level = 1; exactly one entry for the whole strobe.
- IN from 12359 -> one rd_stb pulse with rd_index = 7; OUT to 12346 (odd offset) and to 12361 (out of range) -> no push, no rd_stb.
- /WR low pulse of 2 clk with QUAL_CYCLES = 3 -> no event; then a 4 clk pulse -> one push.
- 5 writes with 0x01..0x05, wr_ready = 0, depth 4 -> level = 4, overflow = 1; drain with wr_ready = 1 -> outputs 0x01..0x04 in order. ovf_clr -> overflow = 0.
- FIFO full with wr_ready = 1 on the CAPTURE cycle of a write 0x77 -> level stays 4, overflow = 0, 0x77 is the last entry out.
- Z80_IO_WAIT_EN defined, FIFO full, write 0x33 -> z80_wait_n low until wr_ready pops one entry, then 0x33 is queued and z80_wait_n = 1; rst_n pulsed mid-stall -> z80_wait_n = 1 immediately, fifo_level = 0.
